// File: rtl/pic10_pkg.sv
// Shared encodings and defaults for the extended PIC10 register file.
package pic10_pkg;

    typedef enum logic [1:0] {
        BOP_WRITE = 2'b00,
        BOP_SET   = 2'b01,
        BOP_CLR   = 2'b10,
        BOP_TGL   = 2'b11
    } bit_op_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_e;

    localparam int INDF_ADDR_DEF = 0;
    localparam int FSR_ADDR_DEF  = 4;

endpackage

// File: rtl/pic10_ram_regfile_ext_if.sv
// Core-side bus of the register file: write strobe, address, ALU data, bit-op control and status.
interface pic10_ram_regfile_ext_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    localparam int BSEL_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              load_ram_reg;
    logic [ADDR_W-1:0] reg_addr_bus;
    logic [DATA_W-1:0] alu_bus;
    logic [1:0]        bit_op;
    logic [BSEL_W-1:0] bit_sel;
    logic [DATA_W-1:0] ram_data_bus;
    logic [DATA_W-1:0] fsr_out;
    logic              busy;
    logic              wr_reject;

    modport master (
        output load_ram_reg, reg_addr_bus, alu_bus, bit_op, bit_sel,
        input  ram_data_bus, fsr_out, busy, wr_reject
    );

    modport slave (
        input  load_ram_reg, reg_addr_bus, alu_bus, bit_op, bit_sel,
        output ram_data_bus, fsr_out, busy, wr_reject
    );

endinterface

// File: rtl/pic10_ram_clear_seq.sv
// Post-reset sequencer: walks every array location once writing zero, then idles in RUN.
module pic10_ram_clear_seq #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);
    import pic10_pkg::*;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_o   = 1'b0;
        clr_we_o = 1'b0;
        case (state_q)
            CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                // Last location is being zeroed on this edge.
                if (cnt_q == '1) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/pic10_ram_regfile_ext.sv
// PIC10 register file with INDF/FSR indirection, bit set/clear/toggle RMW and a
// post-reset clear sequencer so the array itself needs no reset.
module pic10_ram_regfile_ext #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int INDF_ADDR = pic10_pkg::INDF_ADDR_DEF,
    parameter int FSR_ADDR  = pic10_pkg::FSR_ADDR_DEF
) (
    input logic                    clk,
    input logic                    reset,
    pic10_ram_regfile_ext_if.slave bus
);
    import pic10_pkg::*;

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam int                BSEL_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [ADDR_W-1:0] INDF_A = INDF_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] FSR_A  = FSR_ADDR[ADDR_W-1:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] fsr_q, fsr_d;
    logic              wr_reject_q, wr_reject_d;

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] wr_val;
    logic              sel_ok;
    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    function automatic logic [DATA_W-1:0] apply_bit_op(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] rd_val,
        input logic [DATA_W-1:0] wr_data,
        input logic [BSEL_W-1:0] sel
    );
        logic [DATA_W-1:0] mask;
        mask = DATA_W'(1'b1) << sel;
        case (op)
            BOP_SET: return rd_val | mask;
            BOP_CLR: return rd_val & ~mask;
            BOP_TGL: return rd_val ^ mask;
            default: return wr_data;
        endcase
    endfunction

    pic10_ram_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .busy_o    (busy),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    always_comb begin
        ea = bus.reg_addr_bus;
        if (bus.reg_addr_bus == INDF_A) ea = fsr_q[ADDR_W-1:0];
        // An indirect access that lands on INDF itself reads as zero.
        rd = '0;
        if (!busy && (ea != INDF_A)) rd = (ea == FSR_A) ? fsr_q : mem_q[ea];
    end

    always_comb begin
        sel_ok      = (bus.bit_op == BOP_WRITE) || (32'(bus.bit_sel) < DATA_W);
        wr_ok       = bus.load_ram_reg && !busy && (ea != INDF_A) && sel_ok;
        wr_val      = apply_bit_op(bus.bit_op, rd, bus.alu_bus, bus.bit_sel);
        wr_reject_d = bus.load_ram_reg && busy;

        fsr_d = fsr_q;
        if (wr_ok && (ea == FSR_A)) fsr_d = wr_val;

        // The sequencer owns the array write port until the clear completes.
        if (busy) begin
            mem_we    = clr_we;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_ok && (ea != FSR_A);
            mem_waddr = ea;
            mem_wdata = wr_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsr_q       <= '0;
            wr_reject_q <= 1'b0;
        end else begin
            fsr_q       <= fsr_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.ram_data_bus = rd;
    assign bus.fsr_out      = fsr_q;
    assign bus.busy         = busy;
    assign bus.wr_reject    = wr_reject_q;

endmodule

// File: doc/pic10_ram_regfile_ext.md
Name: pic10_ram_regfile_ext

Overview:
Parametrised successor to the PIC10 RAM register file: DEPTH x DATA_W storage with a combinational read port and a single synchronous write port.
Adds four features:
- INDF/FSR indirect addressing.
- Single-cycle bit set, clear and toggle as read-modify-write.
- A post-reset clear sequencer that zeroes every location, so the array can map to block RAM.
- Busy and write-reject status outputs.
Sits between the ALU result bus and the operand mux of the core.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W locations
INDF_ADDR, 0, address that selects indirect access through FSR
FSR_ADDR, 4, address of the FSR register, which is held in flops, not in the array

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high system reset
load_ram_reg  in  1  write strobe; samples alu_bus at the clk rising edge
reg_addr_bus  in  ADDR_W  currently selected register address
alu_bus  in  DATA_W  write data from the ALU
bit_op  in  2  00 = full write, 01 = set bit, 10 = clear bit, 11 = toggle bit
bit_sel  in  $clog2(DATA_W)  bit index for bit_op != 00
ram_data_bus  out  DATA_W  combinational read of the addressed register
fsr_out  out  DATA_W  current FSR value
busy  out  1  clear sequencer active
wr_reject  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset values: fsr=0, busy=1, wr_reject=0, clear counter=0. Reset does not clear the array directly.
- Clear sequencer, two states: CLEAR and RUN.
  - reset asserted -> CLEAR, counter=0.
  - In CLEAR, on each clk edge after reset deasserts: mem[counter]<=0, counter++.
  - After location DEPTH-1 is written -> RUN, busy=0.
  - busy therefore stays high for exactly DEPTH clk edges after reset deasserts.
  - Reset asserted mid-clear (or in RUN) restarts the clear from 0.
- Effective address (ea):
  - ea = fsr[ADDR_W-1:0] if reg_addr_bus == INDF_ADDR; otherwise ea = reg_addr_bus.
  - If the indirect target is INDF_ADDR itself, reads return 0 and writes are ignored without asserting wr_reject.
- Read (combinational):
  - busy=1 -> ram_data_bus = 0.
  - ea == FSR_ADDR -> ram_data_bus = fsr.
  - Otherwise ram_data_bus = mem[ea].
- Write, at the clk edge when load_ram_reg=1 and busy=0:
  - The new value is computed from the current read value rd = ram_data_bus.
  - bit_op 00 -> alu_bus; 01 -> rd | (1<<bit_sel); 10 -> rd & ~(1<<bit_sel); 11 -> rd ^ (1<<bit_sel).
  - ea == FSR_ADDR -> the value goes to fsr; otherwise to mem[ea].
- The read reflects the new value one edge after the write (write-then-read, no bypass).
- bit_sel >= DATA_W (only possible for non-power-of-2 widths): the write is a no-op.
- load_ram_reg=1 while busy=1: the write is dropped and wr_reject=1 for the following cycle. wr_reject is otherwise 0.
- FSR upper bits above ADDR_W are stored and read back but ignored for addressing.
- Widths: all arithmetic is DATA_W bits; no carries and no status flags produced.

Decomposition:
- Shared package pic10_pkg:
  - bit_op encodings BOP_WRITE / BOP_SET / BOP_CLR / BOP_TGL.
  - Default INDF_ADDR / FSR_ADDR constants.
  - A clear-state enum (CLEAR, RUN).
- One natural sub-module, pic10_ram_clear_seq:
  - Owns the counter, state, busy, and the clear-write address/enable.
  - The top muxes its write port between the sequencer and the normal write path.

Test Plan:
- Pulse reset for 3 cycles, then release -> busy=1 for exactly 32 edges, ram_data_bus=00h at all addresses, then busy=0.
- Write alu_bus = addr+1 to every address 00h-1Fh except 00h and 04h -> each address reads back addr+1; addr 04h reads back as fsr.
- Write 13h to addr 04h, then write A5h to addr 00h -> fsr_out=13h; direct read of 13h = A5h; read of 00h = A5h.
- Set fsr=00h, write 5Ah to addr 00h -> no array change, wr_reject=0, read 00h = 00h.
- Set addr 10h = 00h, then apply bit_op=01 with bit_sel=3 -> 08h; then bit_op=11 with bit_sel=0 -> 09h; then bit_op=10 with bit_sel=3 -> 01h.
- Assert load_ram_reg during clear -> wr_reject pulses, location is unchanged (00h). Assert reset at clear count 10 -> busy restarts and lasts a full 32 edges.
